alarm_panel_ctrl: RTL and testbench

Front-panel controller that sequences the Aclock alarm-clock datapath from user buttons. It owns separate edit buffers for the time and alarm settings. It drives the Aclock load bus (H_in1/H_in0/M_in1/M_in0, LD_time, LD_alarm), the alarm enable and stop controls (AL_ON, STOP_al), and a snooze/auto-silence scheduler. It sits between debounced panel buttons and Aclock, on the same 1 Hz clk.

---
 rtl/alarm_panel_pkg.sv | 38 +++
 rtl/alarm_panel_ctrl_if.sv | 39 +++
 rtl/alarm_panel_ctrl_hm_edit_buf.sv | 54 +++++
 rtl/alarm_panel_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_alarm_panel_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_panel_pkg
// Description : Shared state encodings, BCD limits and the HH:MM struct for
//               the alarm front-panel controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_panel_pkg;

    typedef enum logic [2:0] {
        EDIT_IDLE  = 3'd0,
        EDIT_T_HR  = 3'd1,
        EDIT_T_MIN = 3'd2,
        EDIT_A_HR  = 3'd3,
        EDIT_A_MIN = 3'd4,
        EDIT_LOAD  = 3'd5
    } edit_state_e;

    typedef enum logic [1:0] {
        RING_QUIET   = 2'd0,
        RING_RINGING = 2'd1,
        RING_SNOOZED = 2'd2,
        RING_RERING  = 2'd3
    } ring_state_e;

    localparam logic [1:0] HR_MAX_T      = 2'd2;
    localparam logic [3:0] HR_MAX_U_AT_2 = 4'd3;
    localparam logic [3:0] MIN_MAX_T     = 4'd5;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

endpackage
`default_nettype wire

// File: rtl/alarm_panel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_panel_ctrl_if
// Description : Panel buttons, Aclock alarm input and the Aclock load/control
//               bus bundled for the front-panel controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_panel_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_set;
    logic       btn_snooze;
    logic       btn_stop;
    logic       btn_al_en;
    logic       Alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       buzzer;
    logic [2:0] edit_sel;

    modport master (
        output btn_mode, btn_inc, btn_set, btn_snooze, btn_stop, btn_al_en, Alarm,
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
               buzzer, edit_sel
    );

    modport slave (
        input  btn_mode, btn_inc, btn_set, btn_snooze, btn_stop, btn_al_en, Alarm,
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
               buzzer, edit_sel
    );
endinterface
`default_nettype wire

// File: rtl/alarm_panel_ctrl_hm_edit_buf.sv
`default_nettype none
// ============================================================================
// Module      : hm_edit_buf
// Description : One HH:MM BCD edit register with 23:59 wrap-around increments.
// Revision    : 1.0 - initial release
// ============================================================================
module hm_edit_buf
    import alarm_panel_pkg::*;
(
    input  logic    clk,
    input  logic    clear_i,
    input  logic    inc_hr_i,
    input  logic    inc_min_i,
    output bcd_hm_t hm_o
);

    bcd_hm_t hm_q;
    bcd_hm_t hm_d;

    always_comb begin
        hm_d = hm_q;
        if (inc_hr_i) begin
            if (hm_q.h1 == HR_MAX_T && hm_q.h0 == HR_MAX_U_AT_2) begin
                hm_d.h1 = 2'd0;
                hm_d.h0 = 4'd0;
            end else if (hm_q.h0 == 4'd9) begin
                hm_d.h1 = hm_q.h1 + 2'd1;
                hm_d.h0 = 4'd0;
            end else begin
                hm_d.h0 = hm_q.h0 + 4'd1;
            end
        end
        if (inc_min_i) begin
            if (hm_q.m0 == 4'd9) begin
                hm_d.m0 = 4'd0;
                hm_d.m1 = (hm_q.m1 == MIN_MAX_T) ? 4'd0 : hm_q.m1 + 4'd1;
            end else begin
                hm_d.m0 = hm_q.m0 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            hm_q <= '0;
        end else begin
            hm_q <= hm_d;
        end
    end

    assign hm_o = hm_q;

endmodule
`default_nettype wire

// File: rtl/alarm_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_panel_ctrl
// Description : Button-driven edit/load sequencer and snooze/auto-silence
//               scheduler in front of the Aclock alarm-clock datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_panel_ctrl
    import alarm_panel_pkg::*;
#(
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3,
    parameter int CNT_W      = 9
)(
    input  logic              clk,
    input  logic              reset,
    alarm_panel_ctrl_if.slave panel
);

    localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
    localparam logic [CNT_W-1:0] c_ring_ld   = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] c_snooze_ld = CNT_W'(SNOOZE_SEC - 1);
    localparam logic [SNZ_W-1:0] c_max_snz   = SNZ_W'(MAX_SNOOZE);

    logic [5:0] btn_now;
    logic [5:0] btn_q;
    logic [5:0] ev;
    logic       ev_mode, ev_inc, ev_set, ev_snooze, ev_stop, ev_al_en;

    assign btn_now = {panel.btn_al_en, panel.btn_stop, panel.btn_snooze,
                      panel.btn_set, panel.btn_inc, panel.btn_mode};
    assign ev = btn_now & ~btn_q;
    assign {ev_al_en, ev_stop, ev_snooze, ev_set, ev_inc, ev_mode} = ev;

    edit_state_e edit_q, edit_d;
    bcd_hm_t     bus_q, bus_d, bus_view;
    bcd_hm_t     time_hm, alarm_hm;
    logic        ld_time_q, ld_time_d;
    logic        ld_alarm_q, ld_alarm_d;
    logic        t_inc_hr, t_inc_min, a_inc_hr, a_inc_min;

    ring_state_e      ring_q, ring_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             rering_q, rering_d;
    logic             stop_q, stop_d;
    logic             al_on_q, al_on_d;

    hm_edit_buf u_time_buf (
        .clk       (clk),
        .clear_i   (reset),
        .inc_hr_i  (t_inc_hr),
        .inc_min_i (t_inc_min),
        .hm_o      (time_hm)
    );

    hm_edit_buf u_alarm_buf (
        .clk       (clk),
        .clear_i   (reset),
        .inc_hr_i  (a_inc_hr),
        .inc_min_i (a_inc_min),
        .hm_o      (alarm_hm)
    );

    // Edit FSM; set outranks mode, which outranks inc.
    always_comb begin
        edit_d     = edit_q;
        bus_d      = bus_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        t_inc_hr   = 1'b0;
        t_inc_min  = 1'b0;
        a_inc_hr   = 1'b0;
        a_inc_min  = 1'b0;
        case (edit_q)
            EDIT_IDLE: begin
                if (ev_mode) edit_d = EDIT_T_HR;
            end
            EDIT_T_HR, EDIT_T_MIN: begin
                if (ev_set) begin
                    edit_d    = EDIT_LOAD;
                    bus_d     = time_hm;
                    ld_time_d = 1'b1;
                end else if (ev_mode) begin
                    edit_d = (edit_q == EDIT_T_HR) ? EDIT_T_MIN : EDIT_A_HR;
                end else if (ev_inc) begin
                    t_inc_hr  = (edit_q == EDIT_T_HR);
                    t_inc_min = (edit_q == EDIT_T_MIN);
                end
            end
            EDIT_A_HR, EDIT_A_MIN: begin
                if (ev_set) begin
                    edit_d     = EDIT_LOAD;
                    bus_d      = alarm_hm;
                    ld_alarm_d = 1'b1;
                end else if (ev_mode) begin
                    edit_d = (edit_q == EDIT_A_HR) ? EDIT_A_MIN : EDIT_IDLE;
                end else if (ev_inc) begin
                    a_inc_hr  = (edit_q == EDIT_A_HR);
                    a_inc_min = (edit_q == EDIT_A_MIN);
                end
            end
            default: edit_d = EDIT_IDLE;
        endcase
    end

    // The bus follows the buffer under edit so it is already valid in the
    // cycle the set press is seen, then holds the last committed value.
    always_comb begin
        bus_view = bus_q;
        case (edit_q)
            EDIT_T_HR, EDIT_T_MIN: bus_view = time_hm;
            EDIT_A_HR, EDIT_A_MIN: bus_view = alarm_hm;
            default:               bus_view = bus_q;
        endcase
    end

    always_comb begin
        ring_d   = ring_q;
        cnt_d    = cnt_q;
        snz_d    = snz_q;
        rering_d = rering_q;
        stop_d   = 1'b0;
        al_on_d  = ev_al_en ? ~al_on_q : al_on_q;
        if (ev_al_en && al_on_q && ring_q != RING_QUIET) begin
            ring_d   = RING_QUIET;
            stop_d   = 1'b1;
            rering_d = 1'b0;
            snz_d    = '0;
        end else begin
            case (ring_q)
                RING_QUIET: begin
                    if (panel.Alarm && al_on_q) begin
                        ring_d = RING_RINGING;
                        cnt_d  = c_ring_ld;
                    end
                end
                RING_RINGING, RING_RERING: begin
                    if (ev_stop || cnt_q == '0 || (ev_snooze && snz_q == c_max_snz)) begin
                        ring_d   = RING_QUIET;
                        stop_d   = 1'b1;
                        rering_d = 1'b0;
                        snz_d    = '0;
                    end else if (ev_snooze) begin
                        ring_d   = RING_SNOOZED;
                        stop_d   = 1'b1;
                        rering_d = 1'b0;
                        snz_d    = snz_q + 1'b1;
                        cnt_d    = c_snooze_ld;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RING_SNOOZED: begin
                    if (ev_stop) begin
                        ring_d = RING_QUIET;
                        snz_d  = '0;
                    end else if (cnt_q == '0) begin
                        ring_d   = RING_RERING;
                        rering_d = 1'b1;
                        cnt_d    = c_ring_ld;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ring_d = RING_QUIET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q      <= '0;
            edit_q     <= EDIT_IDLE;
            bus_q      <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            ring_q     <= RING_QUIET;
            cnt_q      <= '0;
            snz_q      <= '0;
            rering_q   <= 1'b0;
            stop_q     <= 1'b0;
            al_on_q    <= 1'b0;
        end else begin
            btn_q      <= btn_now;
            edit_q     <= edit_d;
            bus_q      <= bus_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            ring_q     <= ring_d;
            cnt_q      <= cnt_d;
            snz_q      <= snz_d;
            rering_q   <= rering_d;
            stop_q     <= stop_d;
            al_on_q    <= al_on_d;
        end
    end

    assign panel.H_in1    = bus_view.h1;
    assign panel.H_in0    = bus_view.h0;
    assign panel.M_in1    = bus_view.m1;
    assign panel.M_in0    = bus_view.m0;
    assign panel.LD_time  = ld_time_q;
    assign panel.LD_alarm = ld_alarm_q;
    assign panel.STOP_al  = stop_q;
    assign panel.AL_ON    = al_on_q;
    assign panel.buzzer   = panel.Alarm | rering_q;
    assign panel.edit_sel = edit_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_panel_ctrl
// Description : Directed self-checking bench for the alarm front-panel controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_panel_ctrl;

    localparam logic [5:0] B_MODE = 6'b000001;
    localparam logic [5:0] B_INC  = 6'b000010;
    localparam logic [5:0] B_SET  = 6'b000100;
    localparam logic [5:0] B_SNZ  = 6'b001000;
    localparam logic [5:0] B_STOP = 6'b010000;
    localparam logic [5:0] B_ALEN = 6'b100000;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] btn   = '0;
    logic       alarm = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;

    alarm_panel_ctrl_if pif ();

    assign pif.btn_mode   = btn[0];
    assign pif.btn_inc    = btn[1];
    assign pif.btn_set    = btn[2];
    assign pif.btn_snooze = btn[3];
    assign pif.btn_stop   = btn[4];
    assign pif.btn_al_en  = btn[5];
    assign pif.Alarm      = alarm;

    alarm_panel_ctrl #(
        .SNOOZE_SEC (300),
        .RING_SEC   (60),
        .MAX_SNOOZE (3),
        .CNT_W      (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .panel (pif)
    );

    always #5 clk = ~clk;

    logic [13:0] bus_w;
    assign bus_w = {pif.H_in1, pif.H_in0, pif.M_in1, pif.M_in0};

    function automatic logic [13:0] hm(input int h1, input int h0, input int m1, input int m0);
        return {2'(h1), 4'(h0), 4'(m1), 4'(m0)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] mask);
        btn = mask;
        tick();
        btn = '0;
    endtask

    task automatic press(input logic [5:0] mask);
        push(mask);
        tick();
    endtask

    task automatic set_alarm(input logic v);
        alarm = v;
        #1;
    endtask

    task automatic no_rering(input string tag);
        logic saw;
        saw = 1'b0;
        repeat (305) begin
            tick();
            if (pif.buzzer) saw = 1'b1;
        end
        chk(tag, 16'(saw), 16'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " LD_time"},  16'(pif.LD_time),  16'd0);
        chk({tag, " LD_alarm"}, 16'(pif.LD_alarm), 16'd0);
        chk({tag, " STOP_al"},  16'(pif.STOP_al),  16'd0);
        chk({tag, " AL_ON"},    16'(pif.AL_ON),    16'd0);
        chk({tag, " buzzer"},   16'(pif.buzzer),   16'd0);
        chk({tag, " bus"},      16'(bus_w),        16'd0);
        chk({tag, " edit_sel"}, 16'(pif.edit_sel), 16'd0);
    endtask

    initial begin
        logic saw;

        tick();
        tick();
        chk_reset("reset");
        reset = 1'b0;
        tick();

        // Time edit and load
        press(B_MODE);
        chk("sel t_hr", 16'(pif.edit_sel), 16'd1);
        repeat (13) press(B_INC);
        chk("t_hr view 13", 16'(bus_w), 16'(hm(1, 3, 0, 0)));
        push(B_SET);
        chk("ld_time high",      16'(pif.LD_time),  16'd1);
        chk("ld_alarm idle",     16'(pif.LD_alarm), 16'd0);
        chk("bus at ld_time",    16'(bus_w),        16'(hm(1, 3, 0, 0)));
        chk("sel load",          16'(pif.edit_sel), 16'd5);
        tick();
        chk("ld_time one cycle", 16'(pif.LD_time),  16'd0);
        chk("sel idle",          16'(pif.edit_sel), 16'd0);
        chk("bus holds 13:00",   16'(bus_w),        16'(hm(1, 3, 0, 0)));

        // Alarm edit with wrap-around, then load
        repeat (3) press(B_MODE);
        chk("sel a_hr", 16'(pif.edit_sel), 16'd3);
        repeat (23) press(B_INC);
        chk("a_hr 23", 16'(bus_w), 16'(hm(2, 3, 0, 0)));
        press(B_INC);
        chk("a_hr wrap", 16'(bus_w), 16'(hm(0, 0, 0, 0)));
        press(B_MODE);
        chk("sel a_min", 16'(pif.edit_sel), 16'd4);
        repeat (60) press(B_INC);
        chk("a_min wrap", 16'(bus_w), 16'(hm(0, 0, 0, 0)));
        repeat (59) press(B_INC);
        chk("a_min 59", 16'(bus_w), 16'(hm(0, 0, 5, 9)));
        push(B_SET);
        chk("ld_alarm high",      16'(pif.LD_alarm), 16'd1);
        chk("ld_time idle",       16'(pif.LD_time),  16'd0);
        chk("bus at ld_alarm",    16'(bus_w),        16'(hm(0, 0, 5, 9)));
        tick();
        chk("ld_alarm one cycle", 16'(pif.LD_alarm), 16'd0);
        chk("sel idle after a",   16'(pif.edit_sel), 16'd0);

        // Buffers retained; mode+set in T_MIN loads instead of advancing
        press(B_MODE);
        chk("time buf kept", 16'(bus_w), 16'(hm(1, 3, 0, 0)));
        press(B_MODE);
        push(B_MODE | B_SET);
        chk("mode+set sel load", 16'(pif.edit_sel), 16'd5);
        chk("mode+set ld_time",  16'(pif.LD_time),  16'd1);
        chk("mode+set bus",      16'(bus_w),        16'(hm(1, 3, 0, 0)));
        tick();
        press(B_INC);
        chk("inc in idle sel",   16'(pif.edit_sel), 16'd0);
        chk("inc in idle bus",   16'(bus_w),        16'(hm(1, 3, 0, 0)));

        // Auto-stop after RING_SEC
        press(B_ALEN);
        chk("al_on set", 16'(pif.AL_ON), 16'd1);
        set_alarm(1'b1);
        tick();
        chk("buzzer ringing", 16'(pif.buzzer), 16'd1);
        saw = 1'b0;
        repeat (59) begin
            tick();
            if (pif.STOP_al) saw = 1'b1;
        end
        chk("no early auto stop", 16'(saw), 16'd0);
        tick();
        chk("auto stop at 60", 16'(pif.STOP_al), 16'd1);
        set_alarm(1'b0);
        tick();
        chk("auto stop one cycle", 16'(pif.STOP_al), 16'd0);
        chk("buzzer quiet",        16'(pif.buzzer),  16'd0);

        // Three snoozes, each re-ringing after SNOOZE_SEC
        set_alarm(1'b1);
        tick();
        for (int k = 1; k <= 3; k++) begin
            push(B_SNZ);
            chk($sformatf("snooze%0d stop_al", k), 16'(pif.STOP_al), 16'd1);
            set_alarm(1'b0);
            chk($sformatf("snooze%0d silent", k), 16'(pif.buzzer), 16'd0);
            tick();
            repeat (298) tick();
            chk($sformatf("snooze%0d not yet", k), 16'(pif.buzzer), 16'd0);
            tick();
            chk($sformatf("snooze%0d rering", k), 16'(pif.buzzer), 16'd1);
        end
        push(B_SNZ);
        chk("4th snooze stop_al", 16'(pif.STOP_al), 16'd1);
        chk("4th snooze silent",  16'(pif.buzzer),  16'd0);
        no_rering("4th snooze acts as stop");

        // Snooze count was cleared: a fresh occurrence can snooze again
        set_alarm(1'b1);
        tick();
        push(B_SNZ);
        chk("fresh snooze stop_al", 16'(pif.STOP_al), 16'd1);
        set_alarm(1'b0);
        tick();
        repeat (298) tick();
        tick();
        chk("fresh snooze rering", 16'(pif.buzzer), 16'd1);
        push(B_STOP);
        chk("stop in rering stop_al", 16'(pif.STOP_al), 16'd1);
        chk("stop in rering silent",  16'(pif.buzzer),  16'd0);
        tick();

        // Disabling the alarm while snoozed cancels the re-ring
        set_alarm(1'b1);
        tick();
        push(B_SNZ);
        set_alarm(1'b0);
        tick();
        repeat (5) tick();
        push(B_ALEN);
        chk("al_off in snoozed al_on",   16'(pif.AL_ON),   16'd0);
        chk("al_off in snoozed stop_al", 16'(pif.STOP_al), 16'd1);
        no_rering("al_off cancels snooze");

        // Stop wins over a coincident snooze
        press(B_ALEN);
        chk("al_on again", 16'(pif.AL_ON), 16'd1);
        set_alarm(1'b1);
        tick();
        push(B_SNZ | B_STOP);
        chk("snooze+stop stop_al", 16'(pif.STOP_al), 16'd1);
        set_alarm(1'b0);
        no_rering("stop beats snooze");

        // Reset while snoozed and while the load strobe is high
        set_alarm(1'b1);
        tick();
        push(B_SNZ);
        set_alarm(1'b0);
        tick();
        press(B_MODE);
        push(B_SET);
        chk("ld_time before reset", 16'(pif.LD_time), 16'd1);
        reset = 1'b1;
        tick();
        chk_reset("mid reset");
        reset = 1'b0;
        no_rering("no rering after reset");
        press(B_MODE);
        chk("time buf cleared", 16'(bus_w), 16'(hm(0, 0, 0, 0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
